// File: rtl/ecc_alu_seq_if.sv
// Command and response handshake bundle for ecc_alu_seq.
// master = command producer / response consumer, slave = the sequencer.
interface ecc_alu_seq_if #(
  parameter int WID  = 256,
  parameter int TAGW = 4
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [2:0]      cmd_op;
  logic            cmd_msel;
  logic            cmd_swap;
  logic [WID-1:0]  cmd_a;
  logic [WID-1:0]  cmd_b;
  logic [TAGW-1:0] cmd_tag;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [WID-1:0]  rsp_r;
  logic [WID-1:0]  rsp_rswap;
  logic [TAGW-1:0] rsp_tag;
  logic            rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_msel, cmd_swap, cmd_a, cmd_b, cmd_tag, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_r, rsp_rswap, rsp_tag, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_msel, cmd_swap, cmd_a, cmd_b, cmd_tag, rsp_ready,
    output cmd_ready, rsp_valid, rsp_r, rsp_rswap, rsp_tag, rsp_err
  );
endinterface

// File: rtl/ecc_alu_seq.sv
// Buffers ECC field commands in a FIFO and sequences them onto shared add/montmul/inv
// engines, with in-block Montgomery normalisation, constant-time cswap and a watchdog.
module ecc_alu_seq #(
  parameter int             WID   = 256,
  parameter int             DEPTH = 4,
  parameter int             TAGW  = 4,
  parameter int             TMO   = 1024,
  parameter logic [WID-1:0] RSQ0  = WID'(1444),
  parameter logic [WID-1:0] RSQ1  = WID'(256'd1627715501170711445284395025044413883736156588369414752970002579683115011841),
  parameter logic [WID-1:0] NINV  = WID'(1)
) (
  input  logic           clk,
  input  logic           rst,
  ecc_alu_seq_if.slave   bus,
  output logic           busy,
  output logic [WID-1:0] eng_a,
  output logic [WID-1:0] eng_b,
  output logic           eng_msel,
  output logic           add_start,
  input  logic           add_done,
  input  logic [WID-1:0] add_r,
  output logic           mul_start,
  input  logic           mul_done,
  input  logic [WID-1:0] mul_r,
  output logic           inv_start,
  input  logic           inv_done,
  input  logic [WID-1:0] inv_r
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (TMO > 1) ? $clog2(TMO + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TMO > 0) ? TMO - 1 : 0);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_MUL  = 3'b001;
  localparam logic [2:0] OP_INV  = 3'b010;
  localparam logic [2:0] OP_SWAP = 3'b011;

  typedef enum logic [2:0] {IDLE, ADD_W, MUL_W, INV_W, NOR_W, SWAP, RESP} state_t;

  typedef struct packed {
    logic [2:0]      op;
    logic            msel;
    logic            swap;
    logic [WID-1:0]  a;
    logic [WID-1:0]  b;
    logic [TAGW-1:0] tag;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  entry_t          cmd_in;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            full, empty, push, pop;

  state_t          state, state_nxt;
  logic [TW-1:0]   tmo_cnt, tmo_nxt;
  logic            tmo_hit, in_wait;
  logic            add_ok, mul_ok, inv_ok;

  logic            w_swap, w_swap_nxt;
  logic [WID-1:0]  w_a, w_a_nxt, w_b, w_b_nxt, diff;
  logic [WID-1:0]  eng_a_nxt, eng_b_nxt;
  logic            eng_msel_nxt;
  logic            add_start_nxt, mul_start_nxt, inv_start_nxt;
  logic [WID-1:0]  r_q, r_nxt, rswap_q, rswap_nxt;
  logic [TAGW-1:0] tag_q, tag_nxt;
  logic            err_q, err_nxt;

  assign cmd_in = '{op: bus.cmd_op, msel: bus.cmd_msel, swap: bus.cmd_swap,
                    a: bus.cmd_a, b: bus.cmd_b, tag: bus.cmd_tag};
  assign head   = mem[rd_ptr];
  assign full   = (count == (AW+1)'(DEPTH));
  assign empty  = (count == '0);
  assign push   = bus.cmd_valid & ~full;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A done arriving alongside its own start pulse can only be a leftover from an earlier command.
  assign add_ok  = add_done & ~add_start;
  assign mul_ok  = mul_done & ~mul_start;
  assign inv_ok  = inv_done & ~inv_start;
  assign in_wait = (state == ADD_W) || (state == MUL_W) || (state == INV_W) || (state == NOR_W);
  assign tmo_hit = (TMO != 0) && in_wait && (tmo_cnt == TMO_LAST);
  assign diff    = {WID{w_swap}} & (w_a ^ w_b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    pop           = 1'b0;
    add_start_nxt = 1'b0;
    mul_start_nxt = 1'b0;
    inv_start_nxt = 1'b0;
    eng_a_nxt     = eng_a;
    eng_b_nxt     = eng_b;
    eng_msel_nxt  = eng_msel;
    w_swap_nxt    = w_swap;
    w_a_nxt       = w_a;
    w_b_nxt       = w_b;
    r_nxt         = r_q;
    rswap_nxt     = rswap_q;
    tag_nxt       = tag_q;
    err_nxt       = err_q;
    tmo_nxt       = in_wait ? tmo_cnt + 1'b1 : tmo_cnt;

    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          w_swap_nxt = head.swap;
          w_a_nxt    = head.a;
          w_b_nxt    = head.b;
          tag_nxt    = head.tag;
          r_nxt      = '0;
          rswap_nxt  = '0;
          err_nxt    = 1'b0;
          if (head.op == OP_ADD || head.op == OP_MUL || head.op == OP_INV) begin
            eng_a_nxt    = head.a;
            eng_b_nxt    = head.b;
            eng_msel_nxt = head.msel;
          end
          unique case (head.op)
            OP_ADD:  begin state_nxt = ADD_W; add_start_nxt = 1'b1; end
            OP_MUL:  begin state_nxt = MUL_W; mul_start_nxt = 1'b1; end
            OP_INV:  begin state_nxt = INV_W; inv_start_nxt = 1'b1; end
            OP_SWAP: state_nxt = SWAP;
            default: begin state_nxt = RESP; err_nxt = 1'b1; end
          endcase
        end
      end
      ADD_W: begin
        if (add_ok) begin
          r_nxt     = add_r;
          state_nxt = RESP;
        end else if (tmo_hit) begin
          err_nxt   = 1'b1;
          state_nxt = RESP;
        end
      end
      MUL_W: begin
        if (mul_ok) begin
          eng_a_nxt     = mul_r;
          eng_b_nxt     = eng_msel ? RSQ1 : RSQ0;
          mul_start_nxt = 1'b1;
          state_nxt     = NOR_W;
        end else if (tmo_hit) begin
          err_nxt   = 1'b1;
          state_nxt = RESP;
        end
      end
      INV_W: begin
        if (inv_ok) begin
          eng_a_nxt     = inv_r;
          eng_b_nxt     = NINV;
          mul_start_nxt = 1'b1;
          state_nxt     = NOR_W;
        end else if (tmo_hit) begin
          err_nxt   = 1'b1;
          state_nxt = RESP;
        end
      end
      NOR_W: begin
        if (mul_ok) begin
          r_nxt     = mul_r;
          state_nxt = RESP;
        end else if (tmo_hit) begin
          err_nxt   = 1'b1;
          state_nxt = RESP;
        end
      end
      SWAP: begin
        r_nxt     = w_a ^ diff;
        rswap_nxt = w_b ^ diff;
        state_nxt = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (add_start_nxt || mul_start_nxt || inv_start_nxt) tmo_nxt = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt   <= '0;
      add_start <= 1'b0;
      mul_start <= 1'b0;
      inv_start <= 1'b0;
      eng_a     <= '0;
      eng_b     <= '0;
      eng_msel  <= 1'b0;
      w_swap    <= 1'b0;
      w_a       <= '0;
      w_b       <= '0;
      r_q       <= '0;
      rswap_q   <= '0;
      tag_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt   <= tmo_nxt;
      add_start <= add_start_nxt;
      mul_start <= mul_start_nxt;
      inv_start <= inv_start_nxt;
      eng_a     <= eng_a_nxt;
      eng_b     <= eng_b_nxt;
      eng_msel  <= eng_msel_nxt;
      w_swap    <= w_swap_nxt;
      w_a       <= w_a_nxt;
      w_b       <= w_b_nxt;
      r_q       <= r_nxt;
      rswap_q   <= rswap_nxt;
      tag_q     <= tag_nxt;
      err_q     <= err_nxt;
    end
  end

  assign bus.cmd_ready = ~full;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_r     = r_q;
  assign bus.rsp_rswap = rswap_q;
  assign bus.rsp_tag   = tag_q;
  assign bus.rsp_err   = err_q;
  assign busy          = (state != IDLE) || !empty;

endmodule
